// File: rtl/uart_pkg.sv
// Shared UART constants and types used by the receive path.
package uart_pkg;

  localparam int RX_FIFO_DEPTH = 16;

  typedef logic [7:0] byte_t;

endpackage

// File: rtl/rx_fifo_mem.sv
// Byte storage for rx_fifo: one synchronous write port, one asynchronous read port.
module rx_fifo_mem
  import uart_pkg::*;
#(
  parameter int DEPTH = RX_FIFO_DEPTH,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic          Clk,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  byte_t         wr_data,
  input  logic [AW-1:0] rd_addr,
  output byte_t         rd_data
);

  // Contents are deliberately not reset; the reader masks them while empty.
  byte_t mem [DEPTH];

  always_ff @(posedge Clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/rx_fifo.sv
// Receive byte FIFO, first-word-fall-through, with fill level, almost-full
// and a sticky overflow flag. Pushes cannot be stalled; excess bytes are dropped.
module rx_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH     = RX_FIFO_DEPTH,
  parameter int AFULL_LVL = DEPTH - 2,
  localparam int AW = $clog2(DEPTH),
  localparam int PW = AW + 1
) (
  input  logic          Clk,
  input  logic          Rst,
  input  byte_t         Data_In,
  input  logic          Valid_In,
  output byte_t         RX_Data,
  output logic          RX_Empty,
  output logic          RX_Full,
  input  logic          Data_Read,
  output logic          Almost_Full,
  output logic [PW-1:0] Level,
  output logic          Overflow,
  input  logic          Ovf_Clr
);

  logic [PW-1:0] wr_ptr_reg, wr_ptr_next;
  logic [PW-1:0] rd_ptr_reg, rd_ptr_next;
  logic [PW-1:0] level_reg;
  logic          ovf_reg, ovf_next;
  logic          empty, full, push, pop, drop;
  byte_t         head;

  // The MSB of each pointer is a wrap bit, telling full from empty.
  assign empty = (wr_ptr_reg == rd_ptr_reg);
  assign full  = (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]) &&
                 (wr_ptr_reg[AW] != rd_ptr_reg[AW]);

  // A pop in the same cycle frees a slot, so a push into a full FIFO is accepted.
  assign pop  = Data_Read && !empty;
  assign push = Valid_In && (!full || pop);
  assign drop = Valid_In && full && !pop;

  always_comb begin
    wr_ptr_next = wr_ptr_reg;
    rd_ptr_next = rd_ptr_reg;
    ovf_next    = ovf_reg;
    if (push) wr_ptr_next = wr_ptr_reg + PW'(1);
    if (pop)  rd_ptr_next = rd_ptr_reg + PW'(1);
    if (drop)         ovf_next = 1'b1;
    else if (Ovf_Clr) ovf_next = 1'b0;
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      level_reg  <= '0;
      ovf_reg    <= 1'b0;
    end else begin
      wr_ptr_reg <= wr_ptr_next;
      rd_ptr_reg <= rd_ptr_next;
      level_reg  <= wr_ptr_next - rd_ptr_next;
      ovf_reg    <= ovf_next;
    end
  end

  rx_fifo_mem #(
    .DEPTH (DEPTH)
  ) u_mem (
    .Clk     (Clk),
    .wr_en   (push),
    .wr_addr (wr_ptr_reg[AW-1:0]),
    .wr_data (Data_In),
    .rd_addr (rd_ptr_reg[AW-1:0]),
    .rd_data (head)
  );

  assign RX_Data     = empty ? 8'h00 : head;
  assign RX_Empty    = empty;
  assign RX_Full     = full;
  assign Almost_Full = (level_reg >= PW'(AFULL_LVL));
  assign Level       = level_reg;
  assign Overflow    = ovf_reg;

endmodule

// File: tb/tb_rx_fifo.sv
// Self-checking bench for rx_fifo: directed steps plus random traffic,
// all compared against a queue-based model of the FIFO behaviour.
module tb_rx_fifo;
  import uart_pkg::*;

  localparam int DEPTH = 16;
  localparam int AFULL = DEPTH - 2;

  logic       Clk = 1'b0;
  logic       Rst = 1'b1;
  byte_t      Data_In = '0;
  logic       Valid_In = 1'b0;
  byte_t      RX_Data;
  logic       RX_Empty, RX_Full, Data_Read = 1'b0, Almost_Full;
  logic [4:0] Level;
  logic       Overflow;
  logic       Ovf_Clr = 1'b0;

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model: plain queue of bytes plus sticky flag.
  logic [7:0] q [$];
  logic       m_ovf = 1'b0;
  int         max_level = 0;

  rx_fifo #(.DEPTH(DEPTH), .AFULL_LVL(AFULL)) dut (
    .Clk         (Clk),
    .Rst         (Rst),
    .Data_In     (Data_In),
    .Valid_In    (Valid_In),
    .RX_Data     (RX_Data),
    .RX_Empty    (RX_Empty),
    .RX_Full     (RX_Full),
    .Data_Read   (Data_Read),
    .Almost_Full (Almost_Full),
    .Level       (Level),
    .Overflow    (Overflow),
    .Ovf_Clr     (Ovf_Clr)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_model(input string tag);
    logic [7:0] exp_head;
    exp_head = (q.size() == 0) ? 8'h00 : q[0];
    chk({tag, ".empty"}, 32'(RX_Empty), 32'(q.size() == 0));
    chk({tag, ".full"},  32'(RX_Full),  32'(q.size() == DEPTH));
    chk({tag, ".level"}, 32'(Level),    32'(q.size()));
    chk({tag, ".afull"}, 32'(Almost_Full), 32'(q.size() >= AFULL));
    chk({tag, ".ovf"},   32'(Overflow), 32'(m_ovf));
    chk({tag, ".data"},  32'(RX_Data),  32'(exp_head));
  endtask

  // One clock: drive, apply the model's rules, then compare after the edge.
  task automatic cycle(input logic v, input logic [7:0] d, input logic rd,
                       input logic clr, input string tag);
    logic was_full, popped;
    Valid_In  = v;
    Data_In   = d;
    Data_Read = rd;
    Ovf_Clr   = clr;
    was_full  = (q.size() == DEPTH);
    popped    = rd && (q.size() != 0);
    if (popped) void'(q.pop_front());
    if (v && was_full && !popped) m_ovf = 1'b1;
    else begin
      if (v) q.push_back(d);
      if (clr) m_ovf = 1'b0;
    end
    if (v && !(was_full && !popped) && clr) m_ovf = 1'b0;
    if (q.size() > max_level) max_level = q.size();
    @(posedge Clk);
    #1;
    Valid_In = 1'b0; Data_Read = 1'b0; Ovf_Clr = 1'b0;
    check_model(tag);
    $display("cycle %-10s v=%0d d=%02h rd=%0d clr=%0d -> level=%0d data=%02h ovf=%0d",
             tag, v, d, rd, clr, Level, RX_Data, Overflow);
  endtask

  task automatic reset_check(input string tag);
    chk({tag, ".empty"}, 32'(RX_Empty), 32'd1);
    chk({tag, ".full"},  32'(RX_Full),  32'd0);
    chk({tag, ".afull"}, 32'(Almost_Full), 32'd0);
    chk({tag, ".level"}, 32'(Level),    32'd0);
    chk({tag, ".ovf"},   32'(Overflow), 32'd0);
    chk({tag, ".data"},  32'(RX_Data),  32'd0);
  endtask

  initial begin
    logic [7:0] d;
    // Reset
    repeat (2) @(posedge Clk);
    #1;
    reset_check("reset");
    Rst = 1'b0;

    // Three pushes, three pops
    cycle(1'b1, 8'h11, 1'b0, 1'b0, "push11");
    chk("first_push.empty", 32'(RX_Empty), 32'd0);
    chk("first_push.data",  32'(RX_Data),  32'h11);
    cycle(1'b1, 8'h22, 1'b0, 1'b0, "push22");
    cycle(1'b1, 8'h33, 1'b0, 1'b0, "push33");
    chk("three.level", 32'(Level), 32'd3);
    for (int i = 0; i < 3; i++) begin
      chk("pop3.data", 32'(RX_Data), 32'(8'h11 * (i + 1)));
      cycle(1'b0, 8'h00, 1'b1, 1'b0, "pop");
    end
    chk("pop3.empty", 32'(RX_Empty), 32'd1);

    // Fill, overflow, drain
    for (int i = 0; i < DEPTH; i++) cycle(1'b1, 8'(i), 1'b0, 1'b0, "fill");
    chk("fill.full",  32'(RX_Full), 32'd1);
    chk("fill.level", 32'(Level),   32'd16);
    cycle(1'b1, 8'hAA, 1'b0, 1'b0, "dropAA");
    chk("drop.ovf", 32'(Overflow), 32'd1);
    for (int i = 0; i < DEPTH; i++) begin
      chk("drain.data", 32'(RX_Data), 32'(i));
      cycle(1'b0, 8'h00, 1'b1, 1'b0, "drain");
    end
    cycle(1'b0, 8'h00, 1'b0, 1'b1, "ovfclr");

    // Push together with pop while full
    for (int i = 0; i < DEPTH; i++) cycle(1'b1, 8'(i), 1'b0, 1'b0, "fill2");
    chk("fullpp.head", 32'(RX_Data), 32'h00);
    cycle(1'b1, 8'h55, 1'b1, 1'b0, "fullpp");
    chk("fullpp.full", 32'(RX_Full),  32'd1);
    chk("fullpp.ovf",  32'(Overflow), 32'd0);
    for (int i = 0; i < DEPTH - 1; i++) cycle(1'b0, 8'h00, 1'b1, 1'b0, "drain2");
    chk("fullpp.last", 32'(RX_Data), 32'h55);
    cycle(1'b0, 8'h00, 1'b1, 1'b0, "drain2");

    // Pop while empty, then push+pop while empty
    cycle(1'b0, 8'h00, 1'b1, 1'b0, "emptypop");
    cycle(1'b1, 8'h6C, 1'b1, 1'b0, "emptypp");
    chk("emptypp.level", 32'(Level),   32'd1);
    chk("emptypp.data",  32'(RX_Data), 32'h6C);

    // 40 push/pop pairs at a fixed mid level so both pointers wrap
    for (int i = 0; i < 4; i++) cycle(1'b1, 8'($urandom), 1'b0, 1'b0, "prefill");
    max_level = 0;
    for (int i = 0; i < 40; i++) cycle(1'b1, 8'($urandom), 1'b1, 1'b0, "pair");

    // Random mixed traffic
    for (int i = 0; i < 300; i++) begin
      d = 8'($urandom);
      cycle(1'($urandom_range(0, 3) != 0), d, 1'($urandom_range(0, 2) == 0),
            1'($urandom_range(0, 15) == 0), "rand");
    end
    for (int i = 0; i < 300; i++) begin
      d = 8'($urandom);
      cycle(1'($urandom_range(0, 2) == 0), d, 1'($urandom_range(0, 3) != 0),
            1'($urandom_range(0, 15) == 0), "rand2");
    end
    chk("max_level", 32'(max_level <= DEPTH), 32'd1);

    // Reset mid-operation with Level=7 and Overflow=1
    while (q.size() != 0) cycle(1'b0, 8'h00, 1'b1, 1'b0, "flush");
    for (int i = 0; i < DEPTH; i++) cycle(1'b1, 8'($urandom), 1'b0, 1'b0, "fill3");
    cycle(1'b1, 8'hEE, 1'b0, 1'b0, "drop3");
    for (int i = 0; i < 9; i++) cycle(1'b0, 8'h00, 1'b1, 1'b0, "to7");
    chk("pre_rst.level", 32'(Level),    32'd7);
    chk("pre_rst.ovf",   32'(Overflow), 32'd1);
    Rst = 1'b1;
    #2;
    reset_check("async_rst");
    @(posedge Clk);
    #1;
    Rst = 1'b0;
    q.delete();
    m_ovf = 1'b0;

    // Ovf_Clr together with an overflowing push: set wins
    for (int i = 0; i < DEPTH; i++) cycle(1'b1, 8'($urandom), 1'b0, 1'b0, "fill4");
    cycle(1'b1, 8'h99, 1'b0, 1'b1, "drop_clr");
    chk("set_wins.ovf", 32'(Overflow), 32'd1);
    cycle(1'b0, 8'h00, 1'b0, 1'b1, "clr_only");
    chk("clr.ovf", 32'(Overflow), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
